mfp_ram_port_arbiter: RTL and testbench

Shares one mfp_dual_port_ram instance, with byte write mask and 1-cycle registered read, between two requesters. Requester A is the CPU-side AHB-Lite slave decoder; requester B is the UART program loader / DMA. A has default priority. B is guaranteed service through a starvation counter, and read data is returned to the owner through a 1-stage tagged pipeline.

---
 rtl/mfp_ram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mfp_ram_port_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mfp_ram_port_arbiter.sv
// mfp_ram_port_arbiter
// Shares one dual-port RAM with a byte write mask and a 1-cycle registered
// read between requester A (CPU-side AHB-Lite decoder, default priority) and
// requester B (UART loader / DMA). B gets a guaranteed slot once it has been
// refused MAX_WAIT cycles in a row. Read data returns through a 1-stage
// tagged pipeline so only the owning requester sees rvalid.
// MAX_WAIT must lie in 1..15.
module mfp_ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESET,

    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [31:0]           a_wdata,
    input  logic [3:0]            a_mask,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [31:0]           a_rdata,

    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [31:0]           b_wdata,
    input  logic [3:0]            b_mask,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [31:0]           b_rdata,

    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [31:0]           ram_write_data,
    output logic [3:0]            ram_write_mask,
    input  logic [31:0]           ram_read_data
);

    typedef enum logic {PRIO_A, PRIO_B}   mode_t;
    typedef enum logic {OWNER_A, OWNER_B} owner_t;

    localparam logic [3:0] LP_LAST_WAIT = 4'(MAX_WAIT - 1);

    mode_t                 r_mode;
    mode_t                 w_mode_next;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_cnt_next;
    logic                  r_rvalid;
    owner_t                r_owner;
    logic [ADDR_WIDTH-1:0] r_last_addr;

    logic                  w_grant_a;
    logic                  w_grant_b;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wmask;
    logic                  w_read_accept;
    owner_t                w_read_owner;

    // Grant: the mode only matters when both requesters ask in the same cycle.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (r_mode == PRIO_A) begin
            w_grant_a = a_req;
            w_grant_b = b_req & ~a_req;
        end else begin
            w_grant_b = b_req;
            w_grant_a = a_req & ~b_req;
        end
    end

    // Next mode and starvation counter; PRIO_B is entered only for the one
    // cycle in which B must be forced through.
    always_comb begin
        w_mode_next     = r_mode;
        w_wait_cnt_next = r_wait_cnt;
        if (!b_req || w_grant_b) begin
            w_wait_cnt_next = '0;
        end else if (r_wait_cnt != 4'hF) begin
            w_wait_cnt_next = r_wait_cnt + 4'd1;
        end
        case (r_mode)
            PRIO_A:  if (b_req && !w_grant_b && (r_wait_cnt == LP_LAST_WAIT)) w_mode_next = PRIO_B;
            PRIO_B:  if (w_grant_b || !b_req) w_mode_next = PRIO_A;
            default: w_mode_next = PRIO_A;
        endcase
    end

    // RAM drive mux; with no grant the address falls back to the registered
    // last address so the RAM never sees an undriven value.
    always_comb begin
        w_addr        = r_last_addr;
        w_wdata       = '0;
        w_wmask       = '0;
        w_read_accept = 1'b0;
        w_read_owner  = OWNER_A;
        if (w_grant_a) begin
            w_addr        = a_addr;
            w_wdata       = a_wdata;
            w_wmask       = a_write ? a_mask : 4'b0000;
            w_read_accept = ~a_write;
            w_read_owner  = OWNER_A;
        end else if (w_grant_b) begin
            w_addr        = b_addr;
            w_wdata       = b_wdata;
            w_wmask       = b_write ? b_mask : 4'b0000;
            w_read_accept = ~b_write;
            w_read_owner  = OWNER_B;
        end
    end

    // Mode, counter, last-address and tagged read-return registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_mode      <= PRIO_A;
            r_wait_cnt  <= '0;
            r_rvalid    <= 1'b0;
            r_owner     <= OWNER_A;
            r_last_addr <= '0;
        end else begin
            r_mode      <= w_mode_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_rvalid    <= w_read_accept;
            r_last_addr <= w_addr;
            if (w_read_accept) begin
                r_owner <= w_read_owner;
            end
        end
    end

    assign a_ready        = w_grant_a;
    assign b_ready        = w_grant_b;

    assign ram_read_addr  = w_addr;
    assign ram_write_addr = w_addr;
    assign ram_write_data = w_wdata;
    // Writes are blocked while reset is held so the RAM sees a zero mask.
    assign ram_write_mask = HRESET ? 4'b0000 : w_wmask;

    // A reset arriving in the return cycle kills the pending read pulse.
    assign a_rvalid       = r_rvalid & (r_owner == OWNER_A) & ~HRESET;
    assign b_rvalid       = r_rvalid & (r_owner == OWNER_B) & ~HRESET;
    assign a_rdata        = ram_read_data;
    assign b_rdata        = ram_read_data;

endmodule

// File: tb/tb_mfp_ram_port_arbiter.sv
// Testbench for mfp_ram_port_arbiter: directed stimulus with hand-computed
// expectations; read returns are checked by a scoreboard monitor.
module tb_mfp_ram_port_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        a_req, a_write, b_req, b_write;
    logic [5:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_mask, b_mask;
    logic        a_ready, a_rvalid, b_ready, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [5:0]  ram_read_addr, ram_write_addr;
    logic [31:0] ram_write_data, ram_read_data;
    logic [3:0]  ram_write_mask;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic        owner;  // 0 = A, 1 = B
        int          due;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    mfp_ram_port_arbiter #(.ADDR_WIDTH(6), .MAX_WAIT(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data), .ram_write_mask(ram_write_mask),
        .ram_read_data(ram_read_data)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Behavioural dual-port RAM: registered read returns old data on a collision.
    logic [31:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    end
    always @(posedge HCLK) begin
        ram_read_data <= mem[ram_read_addr];
        for (int l = 0; l < 4; l++) begin
            if (ram_write_mask[l]) mem[ram_write_addr][8*l +: 8] <= ram_write_data[8*l +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic wr, input logic [5:0] addr,
                         input logic [31:0] wd, input logic [3:0] m);
        a_req = req; a_write = wr; a_addr = addr; a_wdata = wd; a_mask = m;
    endtask

    task automatic set_b(input logic req, input logic wr, input logic [5:0] addr,
                         input logic [31:0] wd, input logic [3:0] m);
        b_req = req; b_write = wr; b_addr = addr; b_wdata = wd; b_mask = m;
    endtask

    // Check the grant and write mask for this cycle; queue the read return if one is expected.
    task automatic step(input logic ear, input logic ebr, input logic [3:0] emask,
                        input logic [31:0] edata, input logic push);
        exp_t e;
        #2;
        chk("a_ready", {31'b0, a_ready}, {31'b0, ear});
        chk("b_ready", {31'b0, b_ready}, {31'b0, ebr});
        chk("ram_write_mask", {28'b0, ram_write_mask}, {28'b0, emask});
        if (push) begin
            e.owner = ebr;
            e.due   = cyc + 1;
            e.data  = edata;
            sb.push_back(e);
        end
        @(posedge HCLK);
        #1;
    endtask

    // Monitor: every rvalid must match the head of the scoreboard in owner, cycle and data.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("a_rvalid", {31'b0, a_rvalid}, {31'b0, ~e.owner});
                chk("b_rvalid", {31'b0, b_rvalid}, {31'b0, e.owner});
                chk("rdata", e.owner ? b_rdata : a_rdata, e.data);
            end else if (a_rvalid || b_rvalid) begin
                chk("spurious_rvalid", {30'b0, a_rvalid, b_rvalid}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        @(posedge HCLK);
        #1;

        // Reset, idle: no ready, no rvalid, zero mask
        for (int i = 0; i < 2; i++) begin
            chk("a_rvalid_rst", {31'b0, a_rvalid}, 32'h0);
            chk("b_rvalid_rst", {31'b0, b_rvalid}, 32'h0);
            step(0, 0, 4'h0, 0, 0);
        end
        HRESET = 1'b0;

        // A write then read back, byte mask merge, zero-mask write is a no-op
        set_a(1, 1, 5, 32'hDEADBEEF, 4'hF);  step(1, 0, 4'hF, 0, 0);
        set_a(1, 0, 5, 0, 4'hF);              step(1, 0, 4'h0, 32'hDEADBEEF, 1);
        set_a(1, 1, 3, 32'h11223344, 4'hF);  step(1, 0, 4'hF, 0, 0);
        set_a(1, 1, 3, 32'hAABBCCDD, 4'h2);  step(1, 0, 4'h2, 0, 0);
        set_a(1, 0, 3, 0, 4'h0);              step(1, 0, 4'h0, 32'h1122CC44, 1);
        set_a(1, 1, 3, 32'hFFFFFFFF, 4'h0);  step(1, 0, 4'h0, 0, 0);
        set_a(1, 0, 3, 0, 4'h0);              step(1, 0, 4'h0, 32'h1122CC44, 1);
        set_a(0, 0, 0, 0, 0);                 step(0, 0, 4'h0, 0, 0);

        // B alone: write then read of the same address returns new data
        set_b(1, 1, 7, 32'h12345678, 4'hF);  step(0, 1, 4'hF, 0, 0);
        set_b(1, 0, 7, 0, 4'h0);              step(0, 1, 4'h0, 32'h12345678, 1);

        // Alternating uncontended reads: back-to-back pulses to alternating owners
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                set_a(1, 0, 1, 0, 0); set_b(0, 0, 0, 0, 0); step(1, 0, 4'h0, 32'd1, 1);
            end else begin
                set_a(0, 0, 0, 0, 0); set_b(1, 0, 2, 0, 0); step(0, 1, 4'h0, 32'd2, 1);
            end
        end
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0); step(0, 0, 4'h0, 0, 0);

        // Starvation under continuous contention: A,A,A,A,B repeating
        set_a(1, 1, 10, 32'hA0A0A0A0, 4'hF);
        set_b(1, 1, 11, 32'hB0B0B0B0, 4'hF);
        for (int i = 0; i < 10; i++) step(i % 5 != 4, i % 5 == 4, 4'hF, 0, 0);

        // Contended reads: every cycle returns data to the right owner, no gaps
        set_a(1, 0, 1, 0, 0);
        set_b(1, 0, 2, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) step(0, 1, 4'h0, 32'd2, 1);
            else            step(1, 0, 4'h0, 32'd1, 1);
        end

        // Values written during the starvation run
        set_a(1, 0, 10, 0, 0); set_b(0, 0, 0, 0, 0); step(1, 0, 4'h0, 32'hA0A0A0A0, 1);
        set_a(0, 0, 0, 0, 0);  set_b(1, 0, 11, 0, 0); step(0, 1, 4'h0, 32'hB0B0B0B0, 1);
        set_b(0, 0, 0, 0, 0);  step(0, 0, 4'h0, 0, 0);

        // Reset in the cycle after a B read acceptance: rvalid suppressed
        set_b(1, 0, 2, 0, 0);  step(0, 1, 4'h0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        HRESET = 1'b1;          step(0, 0, 4'h0, 0, 0);
        HRESET = 1'b0;
        set_a(1, 1, 20, 32'h20202020, 4'hF);
        set_b(1, 1, 21, 32'h21212121, 4'hF);
        for (int i = 0; i < 5; i++) step(i != 4, i == 4, 4'hF, 0, 0);

        // Reset after 3 refusals of B clears the counter: full 4-cycle wait again
        for (int i = 0; i < 3; i++) step(1, 0, 4'hF, 0, 0);
        HRESET = 1'b1;          step(1, 0, 4'h0, 0, 0);
        HRESET = 1'b0;
        for (int i = 0; i < 5; i++) step(i != 4, i == 4, 4'hF, 0, 0);

        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 0, 0);
        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
